muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit that sits beside the EXE stage.
- Executes MULT/MULTU, DIV/DIVU and MADD/MADDU/MSUB/MSUBU for HI/LO.
- Holds the pipeline through stallreq_o while it iterates, then presents the HI/LO write for exactly one cycle.
- Adds division, accumulate modes, annulment and configurable latency, none of which the combinational EXE multiplier has.

---
 rtl/muldiv_unit_if.sv | 30 +++
 rtl/muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between the EXE stage and the multiply/divide unit
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic                 start_i;
  logic [2:0]           op_i;
  logic [WIDTH-1:0]     opa_i;
  logic [WIDTH-1:0]     opb_i;
  logic [2*WIDTH-1:0]   hilo_i;
  logic                 annul_i;
  logic                 stallreq_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 whilo_o;
  logic [WIDTH-1:0]     hi_o;
  logic [WIDTH-1:0]     lo_o;
  logic                 div_by_zero_o;

  // Pipeline side: issues requests, consumes the HI/LO write
  modport master (
    output start_i, op_i, opa_i, opb_i, hilo_i, annul_i,
    input  stallreq_o, busy_o, done_o, whilo_o, hi_o, lo_o, div_by_zero_o
  );

  // Unit side
  modport slave (
    input  start_i, op_i, opa_i, opb_i, hilo_i, annul_i,
    output stallreq_o, busy_o, done_o, whilo_o, hi_o, lo_o, div_by_zero_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MULT/DIV/MADD/MSUB unit producing a one-cycle HI/LO write
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic          clk,
  input  logic          resetn,
  muldiv_unit_if.slave  bus
);

  localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Operands captured at acceptance; the inputs are not looked at again
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [2*WIDTH-1:0] hilo_r;
  logic               dbz_r;
  logic [CW-1:0]      cnt;

  // Restoring divider: partial remainder, dividend/quotient shifter, divisor magnitude
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quo_r;
  logic [WIDTH:0]     div_b_r;

  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  // Request decode
  logic           accept;
  logic           req_is_div;
  logic           req_sgn;
  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;

  assign accept     = (state == S_IDLE) && bus.start_i && !bus.annul_i;
  assign req_is_div = (bus.op_i[2:1] == 2'b01);
  assign req_sgn    = !bus.op_i[0];
  // One extra bit keeps the magnitude of the most-negative operand representable
  assign a_ext      = {req_sgn & bus.opa_i[WIDTH-1], bus.opa_i};
  assign b_ext      = {req_sgn & bus.opb_i[WIDTH-1], bus.opb_i};

  // Multiply path: sign/zero-extend to 2*WIDTH so the truncated product is exact modulo 2^(2*WIDTH)
  logic               sgn;
  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_b;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mul_res;

  assign sgn     = !op_r[0];
  assign mul_a   = {{WIDTH{sgn & a_r[WIDTH-1]}}, a_r};
  assign mul_b   = {{WIDTH{sgn & b_r[WIDTH-1]}}, b_r};
  assign prod    = mul_a * mul_b;
  assign mul_res = !op_r[2] ? prod :
                   (op_r[1] ? (hilo_r - prod) : (hilo_r + prod));

  // Divide step: one quotient bit per cycle
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] quo_fin;
  logic [WIDTH-1:0] rem_fin;

  assign rem_sh  = {rem_r, quo_r[WIDTH-1]};
  assign div_ge  = (rem_sh >= div_b_r);
  assign rem_nxt = div_ge ? WIDTH'(rem_sh - div_b_r) : rem_sh[WIDTH-1:0];
  assign quo_nxt = {quo_r[WIDTH-2:0], div_ge};
  // Quotient sign follows the operand signs, remainder follows the dividend;
  // min / -1 falls out as quotient = min, remainder = 0
  assign quo_fin = (sgn & (a_r[WIDTH-1] ^ b_r[WIDTH-1])) ? -quo_nxt : quo_nxt;
  assign rem_fin = (sgn & a_r[WIDTH-1]) ? -rem_nxt : rem_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; annul returns to IDLE from any busy state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!req_is_div) begin
            state_nxt = S_MUL;
          end else if (bus.opb_i == '0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (bus.annul_i) begin
          state_nxt = S_IDLE;
        end else if (cnt == MUL_LAST) begin
          state_nxt = S_DONE;
        end
      end
      S_DIV: begin
        if (bus.annul_i) begin
          state_nxt = S_IDLE;
        end else if (cnt == DIV_LAST) begin
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture, iteration and result registers; HI/LO load on the edge into DONE
  always_ff @(posedge clk) begin
    if (resetn) begin
      op_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      hilo_r  <= '0;
      dbz_r   <= 1'b0;
      cnt     <= '0;
      rem_r   <= '0;
      quo_r   <= '0;
      div_b_r <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_r    <= bus.op_i;
            a_r     <= bus.opa_i;
            b_r     <= bus.opb_i;
            hilo_r  <= bus.hilo_i;
            dbz_r   <= req_is_div && (bus.opb_i == '0);
            cnt     <= '0;
            rem_r   <= '0;
            quo_r   <= WIDTH'(a_ext[WIDTH] ? -a_ext : a_ext);
            div_b_r <= b_ext[WIDTH] ? -b_ext : b_ext;
          end
        end
        S_MUL: begin
          cnt <= cnt + CW'(1);
          if (!bus.annul_i && (cnt == MUL_LAST)) begin
            hi_r <= mul_res[2*WIDTH-1:WIDTH];
            lo_r <= mul_res[WIDTH-1:0];
          end
        end
        S_DIV: begin
          cnt   <= cnt + CW'(1);
          rem_r <= rem_nxt;
          quo_r <= quo_nxt;
          if (!bus.annul_i && (cnt == DIV_LAST)) begin
            hi_r <= rem_fin;
            lo_r <= quo_fin;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs; reset and annul override the status pulses combinationally
  always_comb begin
    bus.stallreq_o    = 1'b0;
    bus.busy_o        = 1'b0;
    bus.done_o        = 1'b0;
    bus.whilo_o       = 1'b0;
    bus.div_by_zero_o = 1'b0;
    bus.hi_o          = hi_r;
    bus.lo_o          = lo_r;
    if (!resetn) begin
      bus.stallreq_o    = accept || (state == S_MUL) || (state == S_DIV);
      bus.busy_o        = (state != S_IDLE);
      bus.done_o        = (state == S_DONE) && !bus.annul_i;
      bus.whilo_o       = bus.done_o && !dbz_r;
      bus.div_by_zero_o = bus.done_o && dbz_r;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed-vector bench for muldiv_unit
module tb_muldiv_unit;
  localparam int W = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADDU = 3'b101;
  localparam logic [2:0] OP_MSUB  = 3'b110;

  logic clk = 1'b0;
  logic resetn;
  int   tests = 0;
  int   fails = 0;
  logic [W-1:0] last_hi;
  logic [W-1:0] last_lo;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W), .MUL_CYCLES(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2*W-1:0] hilo);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.opa_i   = a;
    bus.opb_i   = b;
    bus.hilo_i  = hilo;
    #1;
  endtask

  // Starts an operation in the current (idle) cycle, which is cycle 0
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] hilo, input int exp_cyc,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic ewhilo, input logic edbz);
    int   done_cyc;
    logic stall_ok;
    logic got_whilo;
    logic got_dbz;
    logic got_stall;
    logic [W-1:0] got_hi;
    logic [W-1:0] got_lo;
    done_cyc  = -1;
    stall_ok  = 1'b1;
    got_whilo = 1'bx;
    got_dbz   = 1'bx;
    got_stall = 1'bx;
    got_hi    = 'x;
    got_lo    = 'x;
    drive_start(op, a, b, hilo);
    if (bus.stallreq_o !== 1'b1) stall_ok = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      bus.start_i = 1'b0;
      #1;
      if (bus.done_o === 1'b1) begin
        done_cyc  = c;
        got_whilo = bus.whilo_o;
        got_dbz   = bus.div_by_zero_o;
        got_stall = bus.stallreq_o;
        got_hi    = bus.hi_o;
        got_lo    = bus.lo_o;
        break;
      end
      if (bus.stallreq_o !== 1'b1) stall_ok = 1'b0;
    end
    check_val($sformatf("%s done_cycle", tag), 64'(done_cyc), 64'(exp_cyc));
    check_val($sformatf("%s stall_before_done", tag), stall_ok, 1'b1);
    check_val($sformatf("%s stall_in_done", tag), got_stall, 1'b0);
    check_val($sformatf("%s whilo", tag), got_whilo, ewhilo);
    check_val($sformatf("%s dbz", tag), got_dbz, edbz);
    check_val($sformatf("%s hi", tag), got_hi, ehi);
    check_val($sformatf("%s lo", tag), got_lo, elo);
    tick();
    check_val($sformatf("%s idle_after", tag), bus.busy_o, 1'b0);
    last_hi = ehi;
    last_lo = elo;
  endtask

  task automatic watch_no_done(input string tag, input int ncyc);
    int pulses;
    pulses = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (bus.done_o !== 1'b0) pulses++;
      tick();
    end
    check_val($sformatf("%s no_done", tag), 64'(pulses), 64'd0);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.op_i    = '0;
    bus.opa_i   = '0;
    bus.opb_i   = '0;
    bus.hilo_i  = '0;
    bus.annul_i = 1'b0;
    resetn      = 1'b1;
    last_hi     = '0;
    last_lo     = '0;
    tick();
    tick();
    resetn = 1'b0;
    #1;
    check_val("rst stallreq", bus.stallreq_o, 1'b0);
    check_val("rst busy", bus.busy_o, 1'b0);
    check_val("rst done", bus.done_o, 1'b0);
    check_val("rst whilo", bus.whilo_o, 1'b0);
    check_val("rst dbz", bus.div_by_zero_o, 1'b0);
    check_val("rst hilo", {bus.hi_o, bus.lo_o}, 64'd0);

    run_op("div_m7_2",   OP_DIV,   32'hFFFFFFF9, 32'd2,        64'd0, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b0);
    run_op("divu_max",   OP_DIVU,  32'hFFFFFFFF, 32'h10,       64'd0, 33, 32'h0000000F, 32'h0FFFFFFF, 1'b1, 1'b0);
    run_op("div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'd0, 33, 32'h00000000, 32'h80000000, 1'b1, 1'b0);
    run_op("div_7_m2",   OP_DIV,   32'd7,        32'hFFFFFFFE, 64'd0, 33, 32'h00000001, 32'hFFFFFFFD, 1'b1, 1'b0);
    run_op("divu_100_7", OP_DIVU,  32'd100,      32'd7,        64'd0, 33, 32'd2,        32'd14,       1'b1, 1'b0);
    run_op("mult_m2_3",  OP_MULT,  32'hFFFFFFFE, 32'd3,        64'd0, 3,  32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1, 1'b0);
    run_op("multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 3,  32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0);
    run_op("mult_m1_m1", OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 3,  32'h00000000, 32'h00000001, 1'b1, 1'b0);
    run_op("maddu",      OP_MADDU, 32'hFFFFFFFF, 32'd2, 64'h00000001_00000000, 3, 32'd2, 32'hFFFFFFFE, 1'b1, 1'b0);
    run_op("msub",       OP_MSUB,  32'd1,        32'd1,        64'd0, 3,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);

    // Annul while in DONE suppresses the pulse and the write
    drive_start(OP_MULTU, 32'd5, 32'd5, 64'd0);
    tick();
    bus.start_i = 1'b0;
    tick();
    tick();
    bus.annul_i = 1'b1;
    #1;
    check_val("annul_done done", bus.done_o, 1'b0);
    check_val("annul_done whilo", bus.whilo_o, 1'b0);
    tick();
    bus.annul_i = 1'b0;
    #1;
    check_val("annul_done idle", bus.busy_o, 1'b0);

    run_op("preset", OP_MADDU, 32'd0, 32'd0, 64'h00000011_00000022, 3, 32'h11, 32'h22, 1'b1, 1'b0);
    run_op("div_by_0", OP_DIV, 32'd5, 32'd0, 64'd0, 1, 32'h11, 32'h22, 1'b0, 1'b1);

    // Annul in cycle 10 of a DIV, then stay idle through cycle 40
    drive_start(OP_DIV, 32'd100, 32'd3, 64'd0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      bus.start_i = 1'b0;
    end
    bus.annul_i = 1'b1;
    #1;
    check_val("annul_div done_c10", bus.done_o, 1'b0);
    tick();
    bus.annul_i = 1'b0;
    #1;
    check_val("annul_div busy_c11", bus.busy_o, 1'b0);
    watch_no_done("annul_div", 30);
    check_val("annul_div hilo_kept", {bus.hi_o, bus.lo_o}, {last_hi, last_lo});

    // Annul in cycle 10, new request accepted in cycle 11
    drive_start(OP_DIV, 32'd100, 32'd3, 64'd0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      bus.start_i = 1'b0;
    end
    bus.annul_i = 1'b1;
    tick();
    bus.annul_i = 1'b0;
    run_op("after_annul", OP_MULTU, 32'd6, 32'd7, 64'd0, 3, 32'd0, 32'd42, 1'b1, 1'b0);

    // start and annul together in IDLE: not accepted
    bus.annul_i = 1'b1;
    drive_start(OP_DIV, 32'd9, 32'd3, 64'd0);
    check_val("start_annul stallreq", bus.stallreq_o, 1'b0);
    tick();
    check_val("start_annul busy", bus.busy_o, 1'b0);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    tick();

    // Reset in cycle 5 of a DIV discards it
    drive_start(OP_DIV, 32'd100, 32'd7, 64'd0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      bus.start_i = 1'b0;
    end
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    #1;
    check_val("mid_rst busy", bus.busy_o, 1'b0);
    check_val("mid_rst stallreq", bus.stallreq_o, 1'b0);
    check_val("mid_rst done", bus.done_o, 1'b0);
    check_val("mid_rst hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    watch_no_done("mid_rst", 35);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
